// File: rtl/gt_serial_telem_tx_framer_pkg.sv
// Package gt_telem_pkg: link-level constants shared by the telemetry TX framer
// and the RX deframer on the far end.
//  - 8b/10b K/D byte codes and the word encodings built from them
//  - charisk patterns for K-led words and plain data words
//  - CRC-16-CCITT polynomial and initial value
//  - TX framer FSM state type
package gt_telem_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;  // comma, leads every IDLE word
    localparam logic [7:0] K27_7 = 8'hFB;  // start of frame
    localparam logic [7:0] K29_7 = 8'hFD;  // end of frame
    localparam logic [7:0] D10_2 = 8'h4A;  // idle fill byte

    localparam logic [31:0] IDLE_WORD = {D10_2, D10_2, D10_2, K28_5};

    // Only byte0 of a control word is a K character.
    localparam logic [3:0] CHARISK_K0   = 4'b0001;
    localparam logic [3:0] CHARISK_DATA = 4'b0000;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SOF  = 3'd1,
        ST_DATA = 3'd2,
        ST_EOF  = 3'd3,
        ST_GAP  = 3'd4
    } tx_state_e;

    function automatic logic [31:0] sof_word(input logic [15:0] seq);
        return {seq, 8'h00, K27_7};
    endfunction

    function automatic logic [31:0] eof_word(input logic [15:0] crc, input logic [7:0] len);
        return {crc, len, K29_7};
    endfunction

endpackage

// File: rtl/gt_serial_telem_tx_framer_if.sv
// Payload word stream into the telemetry TX framer.
// Handshake: a word transfers on a clock edge where s_tvalid_in && s_tready_out.
// The source holds s_tdata_in/s_tlast_in stable while s_tvalid_in is high and
// not yet accepted. s_tready_out may be high while s_tvalid_in is low.
//  s_tdata_in   32  payload word
//  s_tvalid_in   1  payload word valid
//  s_tlast_in    1  last payload word of the frame
//  s_tready_out  1  framer can accept a word
interface gt_serial_telem_tx_framer_if;
    logic [31:0] s_tdata_in;
    logic        s_tvalid_in;
    logic        s_tlast_in;
    logic        s_tready_out;

    modport master (output s_tdata_in, output s_tvalid_in, output s_tlast_in, input s_tready_out);
    modport slave  (input s_tdata_in, input s_tvalid_in, input s_tlast_in, output s_tready_out);
endinterface

// File: rtl/gt_serial_telem_tx_framer_crc16_d32.sv
// crc16_d32: combinational CRC-16-CCITT advance over one 32-bit word,
// word taken MSB first.
//  crc_i   16  running CRC before this word
//  data_i  32  payload word
//  crc_o   16  running CRC after this word
module crc16_d32
    import gt_telem_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [31:0] data_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_v;

    always_comb begin
        crc_v = crc_i;
        for (int i = 31; i >= 0; i--) begin
            crc_v = {crc_v[14:0], 1'b0} ^ ((crc_v[15] ^ data_i[i]) ? CRC_POLY : 16'h0000);
        end
        crc_o = crc_v;
    end

endmodule

// File: rtl/gt_serial_telem_tx_framer.sv
// gt_serial_telem_tx_framer: wraps a payload word stream as SOF / DATA... /
// EOF+CRC16 for the GT TX user interface and fills every other cycle with
// K28.5 IDLE words, including a periodic clock-correction IDLE.
// Every output is registered: the word chosen in state S is on the pins next cycle.
//  gt0_txusrclk2_in   clock
//  reset_n_in         asynchronous active-low reset
//  link_up_in         TX path ready; dropping it mid-frame abandons the frame
//  s_axis             payload stream (slave side)
//  gt0_txdata_out     word to GT, byte0 first
//  gt0_txcharisk_out  K flags for gt0_txdata_out
//  frame_count_out    frames completed, also the next SOF sequence number
//  abort_out          1-cycle pulse, frame abandoned on link loss
//  overrun_out        1-cycle pulse, EOF forced at MAX_WORDS without tlast
//  state_dbg_out      current FSM state
module gt_serial_telem_tx_framer
    import gt_telem_pkg::*;
#(
    parameter int MAX_WORDS = 255,
    parameter int CC_PERIOD = 1024,
    parameter int MIN_GAP   = 2
) (
    input  logic        gt0_txusrclk2_in,
    input  logic        reset_n_in,
    input  logic        link_up_in,
    gt_serial_telem_tx_framer_if.slave s_axis,
    output logic [31:0] gt0_txdata_out,
    output logic [3:0]  gt0_txcharisk_out,
    output logic [15:0] frame_count_out,
    output logic        abort_out,
    output logic        overrun_out,
    output tx_state_e   state_dbg_out
);

    localparam logic [7:0]  MAX_LEN  = 8'(MAX_WORDS);
    localparam logic [15:0] CC_LAST  = 16'(CC_PERIOD - 1);
    localparam logic [7:0]  GAP_LAST = 8'(MIN_GAP - 1);

    tx_state_e   state_q, state_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  gap_q, gap_d;
    logic [15:0] cc_q, cc_d;
    logic [15:0] crc_q, crc_d, crc_word;
    logic [15:0] fc_q, fc_d;
    logic [31:0] txdata_q, txdata_d;
    logic [3:0]  charisk_q, charisk_d;
    logic        tready_q, tready_d;
    logic        abort_q, abort_d;
    logic        overrun_q, overrun_d;
    logic        emit_idle;
    logic        cc_due;
    logic        accept;

    crc16_d32 u_crc (
        .crc_i  (crc_q),
        .data_i (s_axis.s_tdata_in),
        .crc_o  (crc_word)
    );

    assign cc_due = (cc_q == CC_LAST);
    // tready_q already excludes cc_due cycles, so a set tready_q means acceptance.
    assign accept = s_axis.s_tvalid_in && tready_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        gap_d     = gap_q;
        crc_d     = crc_q;
        fc_d      = fc_q;
        txdata_d  = IDLE_WORD;
        charisk_d = CHARISK_K0;
        abort_d   = 1'b0;
        overrun_d = 1'b0;
        emit_idle = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (link_up_in && s_axis.s_tvalid_in && !cc_due) state_d = ST_SOF;
            end
            ST_SOF: begin
                if (!link_up_in) begin
                    abort_d = 1'b1;
                    gap_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    txdata_d  = sof_word(fc_q);
                    emit_idle = 1'b0;
                    crc_d     = CRC_INIT;
                    len_d     = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                // A word handshaked on the link-loss cycle belongs to the
                // abandoned frame and is dropped with it.
                if (!link_up_in) begin
                    abort_d = 1'b1;
                    gap_d   = '0;
                    state_d = ST_GAP;
                end else if (accept) begin
                    txdata_d  = s_axis.s_tdata_in;
                    charisk_d = CHARISK_DATA;
                    emit_idle = 1'b0;
                    crc_d     = crc_word;
                    len_d     = len_q + 8'd1;
                    if (s_axis.s_tlast_in || len_d == MAX_LEN) state_d = ST_EOF;
                    overrun_d = !s_axis.s_tlast_in && (len_d == MAX_LEN);
                end
            end
            ST_EOF: begin
                txdata_d  = eof_word(crc_q, len_q);
                emit_idle = 1'b0;
                fc_d      = fc_q + 16'd1;
                gap_d     = '0;
                state_d   = ST_GAP;
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) state_d = ST_IDLE;
                else gap_d = gap_q + 8'd1;
            end
            default: begin
                gap_d   = '0;
                state_d = ST_GAP;
            end
        endcase

        // Any IDLE on the wire doubles as clock correction and restarts the count.
        if (emit_idle) cc_d = '0;
        else if (cc_q != CC_LAST) cc_d = cc_q + 16'd1;
        else cc_d = cc_q;

        // Registered ready looks one cycle ahead so it is low exactly on the
        // cycles where the next word must be a clock-correction IDLE.
        tready_d = (state_d == ST_DATA) && link_up_in && (cc_d != CC_LAST);
    end

    always_ff @(posedge gt0_txusrclk2_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q   <= ST_GAP;
            len_q     <= '0;
            gap_q     <= '0;
            cc_q      <= '0;
            crc_q     <= CRC_INIT;
            fc_q      <= '0;
            txdata_q  <= IDLE_WORD;
            charisk_q <= CHARISK_K0;
            tready_q  <= 1'b0;
            abort_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            gap_q     <= gap_d;
            cc_q      <= cc_d;
            crc_q     <= crc_d;
            fc_q      <= fc_d;
            txdata_q  <= txdata_d;
            charisk_q <= charisk_d;
            tready_q  <= tready_d;
            abort_q   <= abort_d;
            overrun_q <= overrun_d;
        end
    end

    assign s_axis.s_tready_out = tready_q;
    assign gt0_txdata_out      = txdata_q;
    assign gt0_txcharisk_out   = charisk_q;
    assign frame_count_out     = fc_q;
    assign abort_out           = abort_q;
    assign overrun_out         = overrun_q;
    assign state_dbg_out       = state_q;

endmodule

// File: tb/tb_gt_serial_telem_tx_framer.sv
// Bench for gt_serial_telem_tx_framer. Two instances: dut_a (MAX_WORDS=64,
// CC_PERIOD=16) and dut_b (MAX_WORDS=4, default CC_PERIOD); sel picks which one
// the driver feeds and the monitor watches.
module tb_gt_serial_telem_tx_framer;

    localparam logic [35:0] IDLE36 = {4'b0001, 32'h4A4A4ABC};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        link_up;
    logic        sel;
    logic [31:0] drv_data;
    logic        drv_valid;
    logic        drv_last;

    gt_serial_telem_tx_framer_if if_a ();
    gt_serial_telem_tx_framer_if if_b ();

    assign if_a.s_tdata_in  = drv_data;
    assign if_a.s_tvalid_in = drv_valid && !sel;
    assign if_a.s_tlast_in  = drv_last;
    assign if_b.s_tdata_in  = drv_data;
    assign if_b.s_tvalid_in = drv_valid && sel;
    assign if_b.s_tlast_in  = drv_last;

    logic [31:0] tx_a, tx_b;
    logic [3:0]  ck_a, ck_b;
    logic [15:0] fc_a, fc_b;
    logic        ab_a, ab_b, ov_a, ov_b;
    gt_telem_pkg::tx_state_e st_a, st_b;

    gt_serial_telem_tx_framer #(.MAX_WORDS(64), .CC_PERIOD(16), .MIN_GAP(2)) dut_a (
        .gt0_txusrclk2_in  (clk),
        .reset_n_in        (rst_n),
        .link_up_in        (link_up),
        .s_axis            (if_a),
        .gt0_txdata_out    (tx_a),
        .gt0_txcharisk_out (ck_a),
        .frame_count_out   (fc_a),
        .abort_out         (ab_a),
        .overrun_out       (ov_a),
        .state_dbg_out     (st_a)
    );

    gt_serial_telem_tx_framer #(.MAX_WORDS(4), .CC_PERIOD(1024), .MIN_GAP(2)) dut_b (
        .gt0_txusrclk2_in  (clk),
        .reset_n_in        (rst_n),
        .link_up_in        (link_up),
        .s_axis            (if_b),
        .gt0_txdata_out    (tx_b),
        .gt0_txcharisk_out (ck_b),
        .frame_count_out   (fc_b),
        .abort_out         (ab_b),
        .overrun_out       (ov_b),
        .state_dbg_out     (st_b)
    );

    logic [31:0] m_data;
    logic [3:0]  m_charisk;
    logic [15:0] m_fc;
    logic        m_tready, m_abort, m_overrun;
    assign m_data    = sel ? tx_b : tx_a;
    assign m_charisk = sel ? ck_b : ck_a;
    assign m_fc      = sel ? fc_b : fc_a;
    assign m_tready  = sel ? if_b.s_tready_out : if_a.s_tready_out;
    assign m_abort   = sel ? ab_b : ab_a;
    assign m_overrun = sel ? ov_b : ov_a;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [35:0] exp_q[$];
    int exp_fc[2];
    int exp_ovr = 0;
    int exp_abort = 0;
    int abort_cnt = 0;
    int ovr_cnt = 0;
    int inframe_idles = 0;
    int run_len = 0;
    int max_run = 0;
    logic in_frame = 1'b0;

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference CRC-16-CCITT, byte-wise, most significant byte first.
    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [31:0] w);
        logic [15:0] r;
        r = c;
        for (int b = 3; b >= 0; b--) begin
            r = r ^ {w[b*8 +: 8], 8'h00};
            for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [35:0] obs;
        logic [35:0] exp;
        if (rst_n) begin
            obs = {m_charisk, m_data};
            if (m_abort) begin
                abort_cnt++;
                in_frame = 1'b0;
            end
            if (m_overrun) ovr_cnt++;
            if (obs == IDLE36) begin
                if (in_frame) begin
                    inframe_idles++;
                    if (run_len > max_run) max_run = run_len;
                end
                run_len = 0;
            end else begin
                run_len++;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_word", obs, IDLE36);
                end else begin
                    exp = exp_q.pop_front();
                    check("sb_word", obs, exp);
                end
                if (m_charisk == 4'b0001 && m_data[7:0] == 8'hFB) in_frame = 1'b1;
                if (m_charisk == 4'b0001 && m_data[7:0] == 8'hFD) in_frame = 1'b0;
            end
        end else begin
            in_frame = 1'b0;
            run_len  = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_expected(input int n, input logic [31:0] base);
        int maxw, i, chunk, fc;
        logic [15:0] crc;
        logic [31:0] w;
        maxw = sel ? 4 : 64;
        fc = exp_fc[sel];
        i = 0;
        while (i < n) begin
            chunk = (n - i > maxw) ? maxw : n - i;
            exp_q.push_back({4'b0001, 16'(fc), 8'h00, 8'hFB});
            crc = 16'hFFFF;
            for (int j = 0; j < chunk; j++) begin
                w = base + 32'(i + j);
                exp_q.push_back({4'b0000, w});
                crc = crc_model(crc, w);
            end
            exp_q.push_back({4'b0001, crc, 8'(chunk), 8'hFD});
            if (chunk == maxw && i + chunk < n) exp_ovr++;
            fc = (fc + 1) & 32'hFFFF;
            i += chunk;
        end
        exp_fc[sel] = fc;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_word(input logic [31:0] d, input logic last, output int waits);
        waits = 0;
        drv_data  = d;
        drv_last  = last;
        drv_valid = 1'b1;
        while (m_tready !== 1'b1 && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 200) check("accept_timeout", 36'(m_tready), 36'(1));
        @(negedge clk);
    endtask

    task automatic send_frame(input int n, input logic [31:0] base, input int pause_at,
                              input int pause_len, output int stalls);
        int w;
        stalls = 0;
        push_expected(n, base);
        for (int i = 0; i < n; i++) begin
            if (i == pause_at && pause_len > 0) begin
                drv_valid = 1'b0;
                repeat (pause_len) @(negedge clk);
            end
            send_word(base + 32'(i), (i == n - 1), w);
            if (i > 0) stalls += w;
        end
        drv_valid = 1'b0;
        drv_last  = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, 36'(exp_q.size()), 36'(0));
        repeat (3) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int st;
        int w;
        int fc0;
        exp_fc[0] = 0;
        exp_fc[1] = 0;
        rst_n = 1'b0;
        link_up = 1'b0;
        sel = 1'b0;
        drv_data = '0;
        drv_valid = 1'b0;
        drv_last = 1'b0;
        repeat (3) @(negedge clk);

        // reset values of both instances
        check("rst_word_a", {ck_a, tx_a}, IDLE36);
        check("rst_word_b", {ck_b, tx_b}, IDLE36);
        check("rst_tready_a", 36'(if_a.s_tready_out), 36'(0));
        check("rst_tready_b", 36'(if_b.s_tready_out), 36'(0));
        check("rst_fc_a", 36'(fc_a), 36'(0));
        check("rst_fc_b", 36'(fc_b), 36'(0));
        check("rst_pulses_a", 36'({ab_a, ov_a}), 36'(0));
        check("rst_pulses_b", 36'({ab_b, ov_b}), 36'(0));

        rst_n = 1'b1;
        link_up = 1'b1;

        // link up, nothing to send: continuous IDLE, never ready
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_word", {m_charisk, m_data}, IDLE36);
            check("idle_tready", 36'(m_tready), 36'(0));
        end

        // three-word frame
        send_frame(3, 32'h0000_0001, -1, 0, st);
        wait_drain("drain_frame3");
        check("fc_after_frame3", 36'(m_fc), 36'(1));
        check("no_pulses_frame3", 36'(abort_cnt + ovr_cnt), 36'(0));

        // mid-frame valid gap of 5 cycles
        inframe_idles = 0;
        send_frame(8, $urandom, 4, 5, st);
        wait_drain("drain_pause");
        check("pause_idles_ge5", 36'(inframe_idles >= 5), 36'(1));
        check("fc_after_pause", 36'(m_fc), 36'(exp_fc[0]));

        // MAX_WORDS=4 instance: 6 words -> forced EOF then a 2-word frame
        sel = 1'b1;
        repeat (2) @(negedge clk);
        send_frame(6, 32'hB000_0000 | 32'($urandom_range(0, 255)), -1, 0, st);
        wait_drain("drain_overrun");
        check("ovr_count", 36'(ovr_cnt), 36'(exp_ovr));
        check("ovr_expected_one", 36'(exp_ovr), 36'(1));
        check("fc_b_after_ovr", 36'(m_fc), 36'(2));

        // tlast exactly on word MAX_WORDS: normal EOF, no overrun
        send_frame(4, 32'hC000_0010, -1, 0, st);
        wait_drain("drain_exact_max");
        check("no_ovr_exact_max", 36'(ovr_cnt), 36'(1));
        check("fc_b_exact_max", 36'(m_fc), 36'(3));

        // link drops on the second payload word
        sel = 1'b0;
        repeat (2) @(negedge clk);
        fc0 = exp_fc[0];
        exp_q.push_back({4'b0001, 16'(fc0), 8'h00, 8'hFB});
        exp_q.push_back({4'b0000, 32'hC0DE_0001});
        send_word(32'hC0DE_0001, 1'b0, w);
        drv_data = 32'hC0DE_0002;
        link_up = 1'b0;
        @(negedge clk);
        check("abort_idle_word", {m_charisk, m_data}, IDLE36);
        check("abort_pulse", 36'(m_abort), 36'(1));
        check("abort_tready", 36'(m_tready), 36'(0));
        drv_valid = 1'b0;
        exp_abort++;
        @(negedge clk);
        check("abort_one_cycle", 36'(m_abort), 36'(0));
        repeat (3) @(negedge clk);
        link_up = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_fc_unchanged", 36'(m_fc), 36'(fc0));
        check("abort_count", 36'(abort_cnt), 36'(exp_abort));
        check("abort_queue_empty", 36'(exp_q.size()), 36'(0));
        send_frame(2, 32'hD000_0000, -1, 0, st);
        wait_drain("drain_after_abort");
        check("fc_after_abort_frame", 36'(m_fc), 36'(fc0 + 1));

        // 40-word frame with CC_PERIOD=16 and constant valid
        inframe_idles = 0;
        max_run = 0;
        send_frame(40, $urandom, -1, 0, st);
        wait_drain("drain_cc");
        check("cc_run_le_15", 36'(max_run <= 15), 36'(1));
        check("cc_min_idles", 36'(inframe_idles >= 2), 36'(1));
        check("cc_tready_low_matches_idles", 36'(st), 36'(inframe_idles));

        // asynchronous reset in the middle of a frame
        exp_q.push_back({4'b0001, 16'(exp_fc[0]), 8'h00, 8'hFB});
        exp_q.push_back({4'b0000, 32'h1234_5678});
        send_word(32'h1234_5678, 1'b0, w);
        drv_data = 32'h9ABC_DEF0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_word", {m_charisk, m_data}, IDLE36);
        check("async_rst_tready", 36'(m_tready), 36'(0));
        check("async_rst_fc", 36'(m_fc), 36'(0));
        check("async_rst_queue", 36'(exp_q.size()), 36'(0));
        drv_valid = 1'b0;
        drv_last = 1'b0;
        exp_fc[0] = 0;
        exp_fc[1] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_fc", 36'(m_fc), 36'(0));
        check("post_rst_no_eof", 36'(exp_q.size()), 36'(0));

        check("final_abort_count", 36'(abort_cnt), 36'(exp_abort));
        check("final_ovr_count", 36'(ovr_cnt), 36'(exp_ovr));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: time limit reached, observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
